// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parametrised UART transmit path.
//   PARITY_NONE/ODD/EVEN  parity selector values for the PARITY parameter
//   DEFAULT_CLKS_PER_BIT  115200 baud from a 100 MHz clock
//   tx_state_t            transmitter FSM state encoding
//   parity_calc()         parity bit for a (zero-extended) data word
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } tx_state_t;

  // Zero padding above DATA_W does not disturb the XOR reduction, so a single
  // 9-bit argument serves every legal data width.
  function automatic logic parity_calc(input logic [8:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/fifo_ram_sync.sv
// -----------------------------------------------------------------------------
// fifo_ram_sync
// DEPTH x DATA_W storage for the transmit FIFO: one write port and one read
// port whose output is registered (maps onto block RAM).
//   clk_100MHz  system clock
//   wr_en       write strobe, wr_data stored at wr_addr
//   rd_en       read strobe, mem[rd_addr] appears on rd_data after the edge
//   rd_data     registered read data
// -----------------------------------------------------------------------------
module fifo_ram_sync #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_100MHz,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_100MHz) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_param
// UART transmitter fed by a synchronous FIFO. Frame: start bit, DATA_W data
// bits LSB first, optional parity bit, STOP_BITS stop bits. Line idles high.
//   clk_100MHz  system clock
//   reset       synchronous, active-high; aborts any frame, empties the FIFO
//   s_valid     write request; accepted on an edge where s_valid & s_ready
//   s_data      word to transmit
//   s_ready     FIFO not full
//   tx          serial output
//   tx_busy     transmitter not idle
//   fifo_empty  level == 0
//   fifo_afull  level >= AFULL_LVL
//   fifo_full   level == DEPTH
//   fifo_level  number of stored words
// -----------------------------------------------------------------------------
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_W       = 8,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1,
  parameter int DEPTH        = 16,
  parameter int AFULL_LVL    = 12
) (
  input  logic                   clk_100MHz,
  input  logic                   reset,
  input  logic                   s_valid,
  input  logic [DATA_W-1:0]      s_data,
  output logic                   s_ready,
  output logic                   tx,
  output logic                   tx_busy,
  output logic                   fifo_empty,
  output logic                   fifo_afull,
  output logic                   fifo_full,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA   = 4'(DATA_W - 1);
  localparam logic [3:0]    LAST_STOP   = 4'(STOP_BITS - 1);
  localparam logic [LW-1:0] FULL_LVL    = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_TH    = LW'(AFULL_LVL);

  if ((DEPTH < 2) || (DEPTH > 4096) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of 2 in 2..4096");
  end
  if ((AFULL_LVL < 0) || (AFULL_LVL > DEPTH)) begin : g_bad_afull
    $error("AFULL_LVL must not exceed DEPTH");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if ((DATA_W < 5) || (DATA_W > 9)) begin : g_bad_width
    $error("DATA_W must be in 5..9");
  end
  if ((CLKS_PER_BIT < 4) || (CLKS_PER_BIT > 4095)) begin : g_bad_baud
    $error("CLKS_PER_BIT must be in 4..4095");
  end
  if ((PARITY != PARITY_NONE) && (PARITY != PARITY_ODD) && (PARITY != PARITY_EVEN)) begin : g_bad_par
    $error("PARITY must be 0, 1 or 2");
  end

  // ---------------------------------------------------------------- FIFO ----
  tx_state_t         state_reg;
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [LW-1:0]     level_reg;
  logic [DATA_W-1:0] rd_data;
  logic              push;
  logic              pop;

  assign fifo_level = level_reg;
  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == FULL_LVL);
  assign fifo_afull = (level_reg >= AFULL_TH);
  assign s_ready    = ~fifo_full;

  assign push = s_valid & ~fifo_full;
  // The FSM takes the head word only from IDLE; the RAM read issued with the
  // pop lands in rd_data while the FSM sits in LOAD.
  assign pop  = (state_reg == ST_IDLE) && !fifo_empty;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  fifo_ram_sync #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_100MHz (clk_100MHz),
    .wr_en      (push),
    .wr_addr    (wr_ptr_reg),
    .wr_data    (s_data),
    .rd_en      (pop),
    .rd_addr    (rd_ptr_reg),
    .rd_data    (rd_data)
  );

  // ----------------------------------------------------------- TX FSM ------
  logic [CW-1:0]     baud_reg;
  logic [3:0]        bit_cnt_reg;
  logic [DATA_W-1:0] shift_reg;
  logic              par_reg;

  // tx is driven from the state register update so the line never glitches;
  // baud_reg is reloaded at every bit boundary and only counts inside a frame.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      tx          <= 1'b1;
      tx_busy     <= 1'b0;
      baud_reg    <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      par_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            state_reg <= ST_LOAD;
            tx_busy   <= 1'b1;
          end
        end
        ST_LOAD: begin
          shift_reg <= rd_data;
          par_reg   <= parity_calc(9'(rd_data), PARITY);
          tx        <= 1'b0;
          baud_reg  <= BAUD_RELOAD;
          state_reg <= ST_START;
        end
        ST_START: begin
          if (baud_reg == '0) begin
            tx          <= shift_reg[0];
            shift_reg   <= shift_reg >> 1;
            bit_cnt_reg <= '0;
            baud_reg    <= BAUD_RELOAD;
            state_reg   <= ST_DATA;
          end else begin
            baud_reg <= baud_reg - CW'(1);
          end
        end
        ST_DATA: begin
          if (baud_reg == '0) begin
            baud_reg <= BAUD_RELOAD;
            if (bit_cnt_reg == LAST_DATA) begin
              if (PARITY != PARITY_NONE) begin
                tx        <= par_reg;
                state_reg <= ST_PAR;
              end else begin
                tx          <= 1'b1;
                bit_cnt_reg <= '0;
                state_reg   <= ST_STOP;
              end
            end else begin
              tx          <= shift_reg[0];
              shift_reg   <= shift_reg >> 1;
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
          end else begin
            baud_reg <= baud_reg - CW'(1);
          end
        end
        ST_PAR: begin
          if (baud_reg == '0) begin
            tx          <= 1'b1;
            bit_cnt_reg <= '0;
            baud_reg    <= BAUD_RELOAD;
            state_reg   <= ST_STOP;
          end else begin
            baud_reg <= baud_reg - CW'(1);
          end
        end
        ST_STOP: begin
          // bit_cnt_reg counts stop bits so two stop bits are two full periods.
          if (baud_reg == '0) begin
            if (bit_cnt_reg == LAST_STOP) begin
              tx_busy   <= 1'b0;
              state_reg <= ST_IDLE;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              baud_reg    <= BAUD_RELOAD;
            end
          end else begin
            baud_reg <= baud_reg - CW'(1);
          end
        end
        default: begin
          tx        <= 1'b1;
          tx_busy   <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo_param
// Four transmitter configurations share one clock:
//   0: 8N1, 8 clk/bit, DEPTH 4, AFULL 3
//   1: 8E2, 8 clk/bit, DEPTH 16, AFULL 12
//   2: 7O1, 8 clk/bit, DEPTH 8, AFULL 6
//   3: default parameters (868 clk/bit, 8N1, DEPTH 16)
// Accepted words go into a per-instance scoreboard queue together with the
// cycle they were accepted; a monitor per instance decodes each frame on tx
// and compares it, sample by sample, against the frame built from the word,
// and compares the start time against max(accept, previous frame end) + 2.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo_param;
  import uart_pkg::*;

  localparam int CPB [4] = '{8, 8, 8, 868};
  localparam int DW  [4] = '{8, 8, 7, 8};
  localparam int PAR [4] = '{PARITY_NONE, PARITY_EVEN, PARITY_ODD, PARITY_NONE};
  localparam int STP [4] = '{1, 2, 1, 1};

  typedef struct {
    logic [8:0] d;
    int         acc;
  } item_t;

  logic       clk_100MHz = 1'b0;
  logic       rst     [4];
  logic       s_valid [4];
  logic [8:0] s_data  [4];
  wire        s_ready_w [4];
  wire        tx_w      [4];
  wire        busy_w    [4];
  wire        empty_w   [4];
  wire        afull_w   [4];
  wire        full_w    [4];
  wire [2:0]  lvl0;
  wire [4:0]  lvl1;
  wire [3:0]  lvl2;
  wire [4:0]  lvl3;

  int    cyc = 0;
  int    checks = 0;
  int    passes = 0;
  int    fails = 0;
  int    last_end [4];
  item_t sb [4][$];

  always #5 clk_100MHz = ~clk_100MHz;
  always @(posedge clk_100MHz) cyc <= cyc + 1;

  uart_tx_fifo_param #(.CLKS_PER_BIT(8), .DATA_W(8), .PARITY(PARITY_NONE), .STOP_BITS(1),
                       .DEPTH(4), .AFULL_LVL(3)) dut0 (
    .clk_100MHz(clk_100MHz), .reset(rst[0]), .s_valid(s_valid[0]), .s_data(s_data[0][7:0]),
    .s_ready(s_ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .fifo_empty(empty_w[0]),
    .fifo_afull(afull_w[0]), .fifo_full(full_w[0]), .fifo_level(lvl0));

  uart_tx_fifo_param #(.CLKS_PER_BIT(8), .DATA_W(8), .PARITY(PARITY_EVEN), .STOP_BITS(2),
                       .DEPTH(16), .AFULL_LVL(12)) dut1 (
    .clk_100MHz(clk_100MHz), .reset(rst[1]), .s_valid(s_valid[1]), .s_data(s_data[1][7:0]),
    .s_ready(s_ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .fifo_empty(empty_w[1]),
    .fifo_afull(afull_w[1]), .fifo_full(full_w[1]), .fifo_level(lvl1));

  uart_tx_fifo_param #(.CLKS_PER_BIT(8), .DATA_W(7), .PARITY(PARITY_ODD), .STOP_BITS(1),
                       .DEPTH(8), .AFULL_LVL(6)) dut2 (
    .clk_100MHz(clk_100MHz), .reset(rst[2]), .s_valid(s_valid[2]), .s_data(s_data[2][6:0]),
    .s_ready(s_ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .fifo_empty(empty_w[2]),
    .fifo_afull(afull_w[2]), .fifo_full(full_w[2]), .fifo_level(lvl2));

  uart_tx_fifo_param dut3 (
    .clk_100MHz(clk_100MHz), .reset(rst[3]), .s_valid(s_valid[3]), .s_data(s_data[3][7:0]),
    .s_ready(s_ready_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .fifo_empty(empty_w[3]),
    .fifo_afull(afull_w[3]), .fifo_full(full_w[3]), .fifo_level(lvl3));

  function automatic int get_level(input int k);
    case (k)
      0:       return int'(lvl0);
      1:       return int'(lvl1);
      2:       return int'(lvl2);
      default: return int'(lvl3);
    endcase
  endfunction

  // Reference frame: start 0, data LSB first, parity, then stop 1s.
  function automatic int frame_bits(input int k);
    return 1 + DW[k] + ((PAR[k] != PARITY_NONE) ? 1 : 0) + STP[k];
  endfunction

  function automatic logic exp_bit(input int k, input logic [8:0] d, input int i);
    int ones;
    if (i == 0) return 1'b0;
    if (i <= DW[k]) return d[i-1];
    if ((PAR[k] != PARITY_NONE) && (i == DW[k] + 1)) begin
      ones = $countones(d);
      if (PAR[k] == PARITY_EVEN) return (ones % 2) == 1;
      return (ones % 2) == 0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) begin
      passes++;
    end else begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  // Called at edge+1; drives one word across the next edge.
  task automatic push(input int k, input logic [8:0] d, output bit acc);
    item_t it;
    logic [8:0] dm;
    dm = d & 9'((1 << DW[k]) - 1);
    acc = s_ready_w[k];
    s_valid[k] = 1'b1;
    s_data[k]  = dm;
    step();
    s_valid[k] = 1'b0;
    if (acc) begin
      it.d   = dm;
      it.acc = cyc;
      sb[k].push_back(it);
    end
    $display("push inst%0d data=%03h accepted=%0d cycle=%0d", k, dm, acc, cyc);
  endtask

  task automatic wait_idle(input int k, input int budget);
    int t;
    t = 0;
    while ((busy_w[k] || !empty_w[k]) && (t < budget)) begin
      step();
      t++;
    end
    if (busy_w[k] || !empty_w[k]) begin
      checks++;
      fails++;
      $display("FAIL idle_timeout inst%0d: still busy after %0d cycles", k, budget);
    end
  endtask

  task automatic check_status(input int k, input string tag, input int lvl);
    chk($sformatf("%s_tx%0d", tag, k), tx_w[k], 1);
    chk($sformatf("%s_busy%0d", tag, k), busy_w[k], 0);
    chk($sformatf("%s_level%0d", tag, k), get_level(k), lvl);
    chk($sformatf("%s_empty%0d", tag, k), empty_w[k], (lvl == 0) ? 1 : 0);
    chk($sformatf("%s_full%0d", tag, k), full_w[k], 0);
    chk($sformatf("%s_ready%0d", tag, k), s_ready_w[k], 1);
  endtask

  task automatic monitor(input int k);
    item_t it;
    int s, n, bad, aborted;
    forever begin
      @(negedge clk_100MHz);
      if (rst[k] || tx_w[k]) continue;
      s = cyc;
      if (sb[k].size() == 0) begin
        chk($sformatf("unexpected_frame%0d", k), 1, 0);
        while (!tx_w[k]) @(negedge clk_100MHz);
        continue;
      end
      it = sb[k].pop_front();
      chk($sformatf("start_time%0d", k), s,
          ((it.acc > last_end[k]) ? it.acc : last_end[k]) + 2);
      n = frame_bits(k) * CPB[k];
      bad = -1;
      aborted = 0;
      for (int i = 0; i < n; i++) begin
        if (i > 0) @(negedge clk_100MHz);
        if (rst[k]) begin
          aborted = 1;
          break;
        end
        if ((bad < 0) && (tx_w[k] !== exp_bit(k, it.d, i / CPB[k]))) bad = i;
      end
      if (aborted == 0) begin
        chk($sformatf("frame%0d_data%03h_bad_sample", k, it.d), bad, -1);
        last_end[k] = s + n;
        $display("frame inst%0d data=%03h start=%0d", k, it.d, s);
      end else begin
        $display("frame inst%0d data=%03h aborted by reset", k, it.d);
      end
    end
  endtask

  task automatic rand_traffic(input int k, input int n);
    bit a;
    for (int i = 0; i < n; i++) begin
      push(k, 9'($urandom), a);
      repeat ($urandom_range(0, 40)) step();
    end
    wait_idle(k, 4000);
  endtask

  initial begin
    bit a;
    int n0, t;
    int exp_lvl [5] = '{1, 1, 2, 3, 4};

    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1;
      s_valid[k] = 1'b0;
      s_data[k] = '0;
    end
    repeat (3) step();
    for (int k = 0; k < 4; k++) begin
      check_status(k, "reset", 0);
      chk($sformatf("reset_afull%0d", k), afull_w[k], 0);
      rst[k] = 1'b0;
      last_end[k] = cyc;
    end
    fork
      monitor(0);
      monitor(1);
      monitor(2);
      monitor(3);
    join_none

    // Single 8N1 word: start bit at N+2, busy drops 82 clocks after accept.
    push(0, 9'h0A5, a);
    n0 = cyc;
    step();
    chk("a5_tx_at_n1", tx_w[0], 1);
    chk("a5_busy_at_n1", busy_w[0], 1);
    step();
    chk("a5_tx_at_n2", tx_w[0], 0);
    while (cyc < n0 + 81) step();
    chk("a5_busy_at_n81", busy_w[0], 1);
    step();
    chk("a5_busy_at_n82", busy_w[0], 0);
    wait_idle(0, 200);

    // DEPTH=4: six back-to-back pushes, the sixth is refused.
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        chk("full_level", get_level(0), 4);
        chk("full_flag", full_w[0], 1);
        chk("full_afull", afull_w[0], 1);
        chk("full_ready", s_ready_w[0], 0);
      end
      push(0, 9'($urandom), a);
      chk($sformatf("burst_accept%0d", i), a, (i < 5) ? 1 : 0);
      if (i < 5) chk($sformatf("burst_level%0d", i), get_level(0), exp_lvl[i]);
    end
    wait_idle(0, 1000);

    // Push and pop in the same cycle at level 3.
    for (int i = 0; i < 4; i++) push(0, 9'($urandom), a);
    chk("simul_pre_level", get_level(0), 3);
    t = 0;
    while (busy_w[0] && (t < 200)) begin
      step();
      t++;
    end
    chk("simul_idle_level", get_level(0), 3);
    chk("simul_idle_afull", afull_w[0], 1);
    push(0, 9'($urandom), a);
    chk("simul_accept", a, 1);
    chk("simul_level", get_level(0), 3);
    chk("simul_afull", afull_w[0], 1);
    wait_idle(0, 1000);

    // Reset during data bit 4 with two words still queued.
    push(0, 9'h0C3, a);
    n0 = cyc;
    push(0, 9'h011, a);
    push(0, 9'h022, a);
    while (cyc < n0 + 44) step();
    rst[0] = 1'b1;
    step();
    check_status(0, "midreset", 0);
    sb[0].delete();
    last_end[0] = cyc;
    rst[0] = 1'b0;
    push(0, 9'h05A, a);
    wait_idle(0, 200);

    // Parity and two stop bits, then random traffic per configuration.
    push(1, 9'h007, a);
    wait_idle(1, 300);
    push(2, 9'h007, a);
    wait_idle(2, 300);
    rand_traffic(0, 10);
    rand_traffic(1, 10);
    rand_traffic(2, 10);

    // Default parameters: two back-to-back 868-clock/bit frames.
    push(3, 9'h055, a);
    push(3, 9'($urandom), a);
    wait_idle(3, 20000);

    for (int k = 0; k < 4; k++) chk($sformatf("scoreboard_left%0d", k), sb[k].size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", passes, checks);
    $fatal(1, "timeout");
  end

endmodule
